// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter
// Shares one double-precision floating-point adder between NUM_REQ requesters.
// A round-robin pick in IDLE captures one requester's operand pair, the
// sequencer pushes A then B through the adder's store/ack handshakes, collects
// the SUM through the result handshake and returns it to the granted requester
// as a single-cycle pulse. Only one addition is in flight at a time.
//
// Optional feature macro: FP_ARB_TIMEOUT_EN
//   defined   : WAIT_SUM watchdog; after TIMEOUT_CYCLES cycles without a SUM
//               handshake a quiet NaN is returned with Resp_err=1.
//   undefined : WAIT_SUM waits indefinitely, Resp_err is tied to 0.
//
// Ports
//   Clock, Reset              clock (rising edge), async active-low reset
//   Req_valid/Req_a/Req_b     per-requester request and packed operands
//   Req_ready                 one-hot pulse: operands captured
//   Resp_valid/Resp_sum       one-hot pulse and result
//   Resp_err                  result is a timeout NaN
//   Adder_A/B, *_store_bit    operands and strobes to the adder
//   Adder_A_ack/B_ack         adder accepts operand
//   Adder_SUM, _store_bit     adder result and valid
//   Adder_SUM_ack             arbiter accepts result
//
// state    | meaning
// IDLE     | waiting for any Req_valid, round-robin pick
// SEND_A   | Adder_A strobe high until acknowledged
// SEND_B   | Adder_B strobe high until acknowledged
// WAIT_SUM | Adder_SUM_ack high until adder presents the result
// RESPOND  | Resp_valid pulse to the granted requester

module fp_adder_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       Req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] Req_a,
    input  logic [NUM_REQ*WIDTH-1:0] Req_b,
    output logic [NUM_REQ-1:0]       Req_ready,
    output logic [NUM_REQ-1:0]       Resp_valid,
    output logic [WIDTH-1:0]         Resp_sum,
    output logic                     Resp_err,
    output logic [WIDTH-1:0]         Adder_A,
    output logic [WIDTH-1:0]         Adder_B,
    output logic                     Adder_A_store_bit,
    output logic                     Adder_B_store_bit,
    input  logic                     Adder_A_ack,
    input  logic                     Adder_B_ack,
    input  logic [WIDTH-1:0]         Adder_SUM,
    input  logic                     Adder_SUM_store_bit,
    output logic                     Adder_SUM_ack
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fp_adder_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_A   = 3'd1,
        SEND_B   = 3'd2,
        WAIT_SUM = 3'd3,
        RESPOND  = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [GW-1:0]        grant, grant_nxt;
    logic [GW-1:0]        last_grant, last_grant_nxt;
    logic [GW-1:0]        pick;
    logic                 pick_any;
    int                   idx;

    logic [NUM_REQ-1:0]   ready_nxt;
    logic [NUM_REQ-1:0]   resp_valid_nxt;
    logic [WIDTH-1:0]     resp_sum_nxt;
    logic [WIDTH-1:0]     adder_a_nxt;
    logic [WIDTH-1:0]     adder_b_nxt;
    logic                 a_stb_nxt;
    logic                 b_stb_nxt;
    logic                 sum_ack_nxt;

`ifdef FP_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [WIDTH-1:0] QNAN = WIDTH'(64'h7FF8_0000_0000_0000);

    logic [CW-1:0]        wait_cnt, wait_cnt_nxt;
    logic                 err_nxt;
`endif

    // Round-robin search starting one past the last served requester.
    always_comb begin
        pick     = '0;
        pick_any = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_any && Req_valid[GW'(idx)]) begin
                pick_any = 1'b1;
                pick     = GW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        ready_nxt      = '0;
        resp_valid_nxt = '0;
        resp_sum_nxt   = Resp_sum;
        adder_a_nxt    = Adder_A;
        adder_b_nxt    = Adder_B;
        a_stb_nxt      = Adder_A_store_bit;
        b_stb_nxt      = Adder_B_store_bit;
        sum_ack_nxt    = Adder_SUM_ack;
`ifdef FP_ARB_TIMEOUT_EN
        wait_cnt_nxt   = wait_cnt;
        err_nxt        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt       = pick;
                    ready_nxt[pick] = 1'b1;
                    // Adder_A/Adder_B double as the operand latches.
                    adder_a_nxt     = Req_a[int'(pick)*WIDTH +: WIDTH];
                    adder_b_nxt     = Req_b[int'(pick)*WIDTH +: WIDTH];
                    a_stb_nxt       = 1'b1;
                    state_nxt       = SEND_A;
                end
            end
            SEND_A: begin
                if (Adder_A_ack && Adder_A_store_bit) begin
                    a_stb_nxt = 1'b0;
                    b_stb_nxt = 1'b1;
                    state_nxt = SEND_B;
                end
            end
            SEND_B: begin
                if (Adder_B_ack && Adder_B_store_bit) begin
                    b_stb_nxt   = 1'b0;
                    sum_ack_nxt = 1'b1;
`ifdef FP_ARB_TIMEOUT_EN
                    wait_cnt_nxt = '0;
`endif
                    state_nxt   = WAIT_SUM;
                end
            end
            WAIT_SUM: begin
                if (Adder_SUM_store_bit && Adder_SUM_ack) begin
                    sum_ack_nxt           = 1'b0;
                    resp_sum_nxt          = Adder_SUM;
                    resp_valid_nxt[grant] = 1'b1;
                    state_nxt             = RESPOND;
                end
`ifdef FP_ARB_TIMEOUT_EN
                // A real result in the same cycle as expiry takes priority.
                else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    sum_ack_nxt           = 1'b0;
                    resp_sum_nxt          = QNAN;
                    err_nxt               = 1'b1;
                    resp_valid_nxt[grant] = 1'b1;
                    state_nxt             = RESPOND;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
`endif
            end
            RESPOND: begin
                last_grant_nxt = grant;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state             <= IDLE;
            grant             <= '0;
            last_grant        <= GW'(NUM_REQ - 1);
            Req_ready         <= '0;
            Resp_valid        <= '0;
            Resp_sum          <= '0;
            Adder_A           <= '0;
            Adder_B           <= '0;
            Adder_A_store_bit <= 1'b0;
            Adder_B_store_bit <= 1'b0;
            Adder_SUM_ack     <= 1'b0;
        end else begin
            state             <= state_nxt;
            grant             <= grant_nxt;
            last_grant        <= last_grant_nxt;
            Req_ready         <= ready_nxt;
            Resp_valid        <= resp_valid_nxt;
            Resp_sum          <= resp_sum_nxt;
            Adder_A           <= adder_a_nxt;
            Adder_B           <= adder_b_nxt;
            Adder_A_store_bit <= a_stb_nxt;
            Adder_B_store_bit <= b_stb_nxt;
            Adder_SUM_ack     <= sum_ack_nxt;
        end
    end

`ifdef FP_ARB_TIMEOUT_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= '0;
            Resp_err <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            Resp_err <= err_nxt;
        end
    end
`else
    assign Resp_err = 1'b0;
`endif

endmodule

// File: doc/fp_adder_arbiter.md
# fp_adder_arbiter

Round-robin arbiter and sequencer that shares one double-precision Floating_Point_Adder between NUM_REQ requesters (Halley-iteration stages, SQRT control). It captures one requester's operand pair and drives the adder's A/B store/acknowledge handshakes. It collects the SUM through the adder's result handshake and returns it to the granted requester. Only one addition is in flight at a time.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 64, operand/result width (IEEE-754 double)
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT_SUM (used only with FP_ARB_TIMEOUT_EN)

- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Req_valid  in  NUM_REQ  per-requester request; held until Req_ready
- Req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- Req_b  in  NUM_REQ*WIDTH  operand B, same packing
- Req_ready  out  NUM_REQ  one-hot, 1-cycle pulse: operands captured
- Resp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: Resp_sum valid for that requester
- Resp_sum  out  WIDTH  result
- Resp_err  out  1  qualifies Resp_valid: timeout result (macro only, else tied 0)
- Adder_A, Adder_B  out  WIDTH  operands to adder
- Adder_A_store_bit, Adder_B_store_bit  out  1  operand strobes
- Adder_A_ack, Adder_B_ack  in  1  adder ready for operand
- Adder_SUM  in  WIDTH  adder result
- Adder_SUM_store_bit  in  1  adder result valid
- Adder_SUM_ack  out  1  arbiter accepts result

## Operation
- All outputs are registered. On Reset low, all outputs go to 0, state goes to IDLE, and last_grant goes to NUM_REQ-1, so requester 0 wins first.
- IDLE: if any Req_valid, grant the first asserted index searching last_grant+1, +2, … (mod NUM_REQ).
  - Latch Req_a/Req_b of the grant and pulse Req_ready[grant].
  - Go to SEND_A.
  - Requests not asserted in IDLE are ignored (no queuing).
- SEND_A: Adder_A = latched A, Adder_A_store_bit=1. On Adder_A_ack & store_bit, drop the strobe and go to SEND_B.
- SEND_B: same, with B. On transfer, go to WAIT_SUM.
- WAIT_SUM: Adder_SUM_ack=1. On Adder_SUM_store_bit & ack, latch Adder_SUM and go to RESPOND.
- RESPOND: Resp_valid[grant]=1 and Resp_sum=latched sum for exactly one cycle. last_grant←grant, then go to IDLE.
- A requester must deassert Req_valid in the cycle after Req_ready, or it re-requests. Round-robin guarantees every other pending requester is served before a repeat.
- Requesters have no response backpressure. Resp_sum holds its last value until the next RESPOND.
- Reset mid-operation abandons the transaction: no Resp_valid, and the adder strobes drop asynchronously.

## Timing
- Request sampled at edge 0 in IDLE. Req_ready and Adder_A_store_bit are high in cycle 1.
- With the adder acking immediately: SEND_B in cycle 2, WAIT_SUM in cycle 3.
- Resp_valid is asserted 1 cycle after the SUM handshake edge.
- Minimum occupancy is 5 cycles plus the adder compute latency. IDLE always takes at least 1 cycle between transactions.
- Simultaneous Req_valid from all requesters with last_grant=NUM_REQ-1 gives grant order 0,1,2,3.

## Configuration
- FP_ARB_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on entry to WAIT_SUM and increments each WAIT_SUM cycle.
  - When it reaches TIMEOUT_CYCLES without a SUM handshake: go to RESPOND with Resp_sum=64'h7FF8_0000_0000_0000 (quiet NaN) and Resp_err=1, then continue to IDLE.
- FP_ARB_TIMEOUT_EN undefined: no counter, Resp_err is constant 0, and WAIT_SUM waits indefinitely.

## Test plan
- Reset low mid-WAIT_SUM -> all outputs 0 immediately. After release, Req_valid[2] alone gives Req_ready[2] in cycle 1 and no stale Resp_valid.
- Single request: requester 0 sends A=1.0 (3FF0…0) and B=2.0 (4000…0) with an adder model returning 4008…0 (3.0) -> Resp_valid[0] pulses once with Resp_sum=4008_0000_0000_0000.
- All four requesters held valid -> Req_ready order 0,1,2,3,0. Every Resp_valid index matches the preceding grant.
- Adder_A_ack held low for 10 cycles -> Adder_A_store_bit and Adder_A stay stable, and no B strobe until the A transfer.
- Requester 1 keeps Req_valid high after its grant while requester 3 is pending -> requester 3 is granted before requester 1 again.
- With FP_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, the adder never asserts Adder_SUM_store_bit -> after 16 WAIT_SUM cycles, Resp_valid with Resp_err=1 and Resp_sum=7FF8_0000_0000_0000, then the next request is served normally.
